// File: rtl/generic_memory_pipe.sv
// ---------------------------------------------------------------------------
// generic_memory_pipe
//
// Behavioural single-port SRAM used as the technology-independent fallback
// behind the tech_cells memory wrappers (simulation and FPGA builds).
// Supports a depth that is not a power of two and a configurable read
// latency with a QVALID strobe. It also has a clear sequencer that fills the
// array with INIT_VALUE after reset and raises READY when done.
//
// Optional feature macro: GENERIC_MEMORY_PARITY_EN
//   When defined, every byte lane carries one stored even-parity bit. ERR
//   reports a parity mismatch on reads. INJ corrupts the parity of the lanes
//   being written.
//   When undefined, there is no parity storage, ERR is tied low and INJ is
//   unused.
//
// Ports
//   CLK     in   clock, everything on the rising edge
//   RST     in   synchronous active-high reset
//   CEN     in   chip enable, active-low
//   A       in   word address (ADDR_WIDTH)
//   WEN     in   0 = write, 1 = read (only looked at when CEN = 0)
//   D       in   write data (DATA_WIDTH)
//   BEN     in   byte enables, active-low, one per BYTE_WIDTH lane
//   INJ     in   parity-error inject on writes (parity build only)
//   Q       out  read data, holds its last value between reads
//   QVALID  out  one-cycle pulse when Q carries fresh read data
//   ERR     out  parity error, aligned with QVALID
//   READY   out  high when the memory accepts requests
// ---------------------------------------------------------------------------
module generic_memory_pipe #(
  parameter int                      ADDR_WIDTH   = 12,
  parameter int                      NUM_WORDS    = 2**ADDR_WIDTH,
  parameter int                      DATA_WIDTH   = 32,
  parameter int                      BYTE_WIDTH   = 8,
  parameter int                      BE_WIDTH     = DATA_WIDTH / BYTE_WIDTH,
  parameter int                      READ_LATENCY = 1,
  parameter bit                      INIT_CLEAR   = 1'b1,
  parameter logic [DATA_WIDTH-1:0]   INIT_VALUE   = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic                  WEN,
  input  logic [DATA_WIDTH-1:0] D,
  input  logic [BE_WIDTH-1:0]   BEN,
  input  logic                  INJ,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  QVALID,
  output logic                  ERR,
  output logic                  READY
);

  // Depth as a value one bit wider than the address, so an address compare
  // also works when NUM_WORDS == 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0]   NumWordsW = (ADDR_WIDTH+1)'(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clearCnt_q, clearCnt_d;
  logic                    clearWe;

  logic                    ready;
  logic                    accept;
  logic                    inRange;
  logic                    wrEn;
  logic                    rdEn;
  logic [DATA_WIDTH-1:0]   rdWord;
  logic                    rdErr;

  logic [DATA_WIDTH-1:0]   mem_q [NUM_WORDS];

  logic [READ_LATENCY-1:0] pipeValid_q;
  logic [READ_LATENCY-1:0] pipeErr_q;
  logic [DATA_WIDTH-1:0]   pipeData_q [READ_LATENCY];

`ifdef GENERIC_MEMORY_PARITY_EN
  logic [BE_WIDTH-1:0]     par_q [NUM_WORDS];
  logic [BE_WIDTH-1:0]     wrPar;

  // Even parity per lane: the stored bit makes each lane plus its parity
  // bit contain an even number of ones.
  function automatic logic [BE_WIDTH-1:0] lanePar(input logic [DATA_WIDTH-1:0] w);
    logic [BE_WIDTH-1:0] p;
    p = '0;
    for (int b = 0; b < BE_WIDTH; b++) begin
      p[b] = ^w[b*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return p;
  endfunction
`else
  logic                    unusedInj;
`endif

  // State and clear counter. Reset picks the starting state from
  // INIT_CLEAR, so a memory without clearing is ready straight out of reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= INIT_CLEAR ? CLEAR : RUN;
      clearCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      clearCnt_q <= clearCnt_d;
    end
  end

  // The clear pass writes one word per cycle. It leaves for RUN on the same
  // edge that writes the last word, so the pass takes exactly NUM_WORDS
  // cycles. RUN is only left through reset.
  always_comb begin
    state_d    = state_q;
    clearCnt_d = clearCnt_q;
    clearWe    = 1'b0;
    case (state_q)
      CLEAR: begin
        clearWe = ~RST;
        if (clearCnt_q == LastAddr) begin
          state_d = RUN;
        end else begin
          clearCnt_d = clearCnt_q + ADDR_WIDTH'(1);
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Request decode. READY is masked by RST so it drops in the reset cycle
  // itself. Out-of-range writes are dropped here. Out-of-range reads are
  // still accepted so that they return a QVALID with zero data.
  always_comb begin
    ready   = (state_q == RUN) && !RST;
    accept  = ready && (CEN == 1'b0);
    inRange = ({1'b0, A} < NumWordsW);
    wrEn    = accept && !WEN && inRange;
    rdEn    = accept && WEN;
  end

  // Array read port, sampled at the accepting edge by pipeline stage 0.
  always_comb begin
    rdWord = '0;
    rdErr  = 1'b0;
    if (inRange) begin
      rdWord = mem_q[A];
`ifdef GENERIC_MEMORY_PARITY_EN
      rdErr  = |(lanePar(mem_q[A]) ^ par_q[A]);
`endif
    end
  end

`ifdef GENERIC_MEMORY_PARITY_EN
  // Parity written with new data. INJ flips the bit of every written lane.
  always_comb begin
    wrPar = lanePar(D) ^ {BE_WIDTH{INJ}};
  end
`else
  assign unusedInj = INJ;
`endif

  // Storage array. It has no reset: the clear sequencer initialises it, and
  // when INIT_CLEAR is 0 the contents are deliberately left alone. Only
  // lanes with an active-low enable are written.
  always_ff @(posedge CLK) begin
    if (clearWe) begin
      mem_q[clearCnt_q] <= INIT_VALUE;
`ifdef GENERIC_MEMORY_PARITY_EN
      par_q[clearCnt_q] <= lanePar(INIT_VALUE);
`endif
    end else if (wrEn) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (!BEN[b]) begin
          mem_q[A][b*BYTE_WIDTH +: BYTE_WIDTH] <= D[b*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef GENERIC_MEMORY_PARITY_EN
          par_q[A][b] <= wrPar[b];
`endif
        end
      end
    end
  end

  // Read pipeline of READ_LATENCY stages. Stage 0 captures the array at the
  // accepting edge. Each later stage loads data only when a valid token
  // arrives. As a result, the last stage (driving Q) holds its value between
  // reads without any separate hold register. Reset flushes every stage, so
  // in-flight reads are dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pipeValid_q <= '0;
      pipeErr_q   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipeData_q[i] <= '0;
      end
    end else begin
      pipeValid_q[0] <= rdEn;
      if (rdEn) begin
        pipeData_q[0] <= rdWord;
        pipeErr_q[0]  <= rdErr;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
        if (pipeValid_q[i-1]) begin
          pipeData_q[i] <= pipeData_q[i-1];
          pipeErr_q[i]  <= pipeErr_q[i-1];
        end
      end
    end
  end

  assign Q      = pipeData_q[READ_LATENCY-1];
  assign QVALID = pipeValid_q[READ_LATENCY-1];
  // The error flag is held in the pipe like data, but only shown with QVALID.
  assign ERR    = pipeErr_q[READ_LATENCY-1] & pipeValid_q[READ_LATENCY-1];
  assign READY  = ready;

endmodule

// File: doc/generic_memory_pipe.md
Name: generic_memory_pipe

Overview:
Parametrised single-port SRAM behavioural model. Successor to the flat single-cycle generic memory. Adds:
- non-power-of-two depth
- configurable read latency with a valid strobe
- hardware clear-on-reset sequencer with a READY flag
- optional per-byte parity

Used as the technology-independent fallback behind the tech_cells memory wrappers for simulation and FPGA.

Parameters:
ADDR_WIDTH, 12, address bus width.
NUM_WORDS, 2**ADDR_WIDTH, implemented depth; must be 1..2**ADDR_WIDTH.
DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH.
BYTE_WIDTH, 8, bits per byte-enable lane.
BE_WIDTH, DATA_WIDTH/BYTE_WIDTH, number of byte lanes (derived, not overridden).
READ_LATENCY, 1, cycles from accepted read to Q/QVALID; must be >= 1.
INIT_CLEAR, 1, 1 = write INIT_VALUE to every word after reset; 0 = contents untouched.
INIT_VALUE, '0, DATA_WIDTH-bit value written by the clear sequencer.

Ports:
CLK  input  1  clock; all logic on rising edge.
RST  input  1  reset, synchronous, active-high.
CEN  input  1  chip enable, active-low.
A  input  ADDR_WIDTH  word address.
WEN  input  1  0 = write, 1 = read (sampled only when CEN=0).
D  input  DATA_WIDTH  write data.
BEN  input  BE_WIDTH  byte enable, active-low; BEN[i]=0 writes D[i*BYTE_WIDTH +: BYTE_WIDTH].
INJ  input  1  parity-error inject on write (feature only; ignored otherwise).
Q  output  DATA_WIDTH  read data.
QVALID  output  1  one-cycle pulse, Q carries fresh read data.
ERR  output  1  parity error, aligned with QVALID.
READY  output  1  1 = memory accepts requests.

Behaviour:
- Reset and outputs
  - Cycle with RST=1: state <- CLEAR (INIT_CLEAR=1) or RUN (INIT_CLEAR=0).
  - Clear counter <- 0; read pipeline flushed.
  - Q=0, QVALID=0, ERR=0, READY=0.
- States: CLEAR, RUN.
  - CLEAR
    - Each cycle: MEM[cnt] <= INIT_VALUE (parity bits consistent); cnt++.
    - When cnt==NUM_WORDS-1 is written, next state = RUN.
    - Takes exactly NUM_WORDS cycles after RST falls; READY=1 from the following cycle.
    - CEN/WEN ignored; no access, no QVALID.
  - RUN: READY=1; accepts one access per cycle when CEN=0.
  - No other transitions; only RST leaves RUN.
- RST asserted mid-CLEAR: counter restarts at 0 on the next clear pass.
- RST asserted mid-read: in-flight reads are discarded; no QVALID after reset.
- Write (CEN=0, WEN=0, READY=1): lanes with BEN[i]=0 updated at the clock edge; other lanes kept. No QVALID; Q holds.
- Read (CEN=0, WEN=1, READY=1)
  - MEM[A] sampled at the accepting edge.
  - Passes through READ_LATENCY-1 further register stages.
  - Q and QVALID update READ_LATENCY edges after acceptance.
  - Back-to-back reads give back-to-back QVALID.
- Q holds its last read value when QVALID=0; it is never cleared except by RST.
- Write then read of the same address on the next cycle returns the new data.
- Read-first/write-first does not apply (single port; one op per cycle).
- Out-of-range (A >= NUM_WORDS)
  - Write: dropped.
  - Read: still produces QVALID with Q=0, ERR=0.
- BEN is ignored for reads.
- X/Z on CEN when READY=1 is not a legal stimulus; the bench asserts against it.

Optional Feature:
GENERIC_MEMORY_PARITY_EN.
- Defined:
  - Each lane stores one extra even-parity bit, computed from D on write.
  - INJ=1 on a write inverts the stored parity of every written lane.
  - On read, ERR = OR of per-lane parity mismatches, registered with the same latency as Q and pulsed with QVALID.
  - The clear sequencer writes correct parity.
- Undefined: no parity storage; ERR tied 0; INJ unused.

Test Plan:
- Clear timing: NUM_WORDS=10, INIT_CLEAR=1, INIT_VALUE=32'hDEAD_BEEF, RST high 2 cycles then low -> READY=0 for exactly 10 cycles, then 1; reads of addresses 0..9 return DEADBEEF.
- Byte-masked write: write A=5, D=32'h1122_3344, BEN=4'b0000; then write D=32'hAABB_CCDD, BEN=4'b1010; read A=5 -> Q=32'h11BB_33DD.
- Read latency: READ_LATENCY=3; reads A=1,2,3 on consecutive cycles -> QVALID high on cycles 3,4,5 with matching data; Q holds the A=3 data afterwards.
- Reset mid-operation:
  - RST pulse during CLEAR at cnt=4 -> clear restarts, full NUM_WORDS cycles before READY.
  - RST one cycle after a read with latency 3 -> no QVALID emitted.
- Out-of-range: NUM_WORDS=10, write A=12, D=32'hFFFF_FFFF; read A=12 -> Q=0, QVALID=1; read A=9 unchanged.
- Parity (macro on): write A=7 with INJ=1, BEN=4'b1110 -> read A=7 gives ERR=1 with QVALID; rewrite with INJ=0 -> ERR=0.
